// File: rtl/llc_input_arbiter.sv
// Admits one of the four LLC input channels per core pipeline pass. Fixed priority with
// age-based promotion of req/dma; the winner id is held for the core until txn_done.
//
// state | meaning
// IDLE  | no transaction in flight; arbitrate when decode_en and a channel is eligible
// BUSY  | admitted transaction in flight; sel_id held, all readies low until txn_done
module llc_input_arbiter #(
   parameter  int STARVE_MAX = 8,
   localparam int AGE_W      = $clog2(STARVE_MAX + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rst_tb_valid,
   input  logic       rsp_in_valid,
   input  logic       req_in_valid,
   input  logic       dma_req_in_valid,
   input  logic       block_req,
   input  logic       block_dma,
   input  logic       decode_en,
   input  logic       txn_done,
   output logic       rst_tb_ready,
   output logic       rsp_in_ready,
   output logic       req_in_ready,
   output logic       dma_req_in_ready,
   output logic       sel_valid,
   output logic [1:0] sel_id,
   output logic       starve_flag
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);
   localparam logic [1:0] ID_RST = 2'd0;
   localparam logic [1:0] ID_RSP = 2'd1;
   localparam logic [1:0] ID_REQ = 2'd2;
   localparam logic [1:0] ID_DMA = 2'd3;

   state_t           state;
   logic             arm_q;
   logic [AGE_W-1:0] req_age;
   logic [AGE_W-1:0] dma_age;

   logic       elig_req;
   logic       elig_dma;
   logic       req_aged;
   logic       dma_aged;
   logic       arb_en;
   logic       win_any;
   logic       win_aged;
   logic [1:0] win_id;
   logic       grant;

   assign elig_req = req_in_valid & ~block_req;
   assign elig_dma = dma_req_in_valid & ~block_dma;
   assign req_aged = elig_req && (req_age == AGE_MAX);
   assign dma_aged = elig_dma && (dma_age == AGE_MAX);

   // arm_q keeps every ready low in the first cycle out of reset
   assign arb_en = (state == IDLE) && arm_q && decode_en && !rst;

   always_comb begin
      win_any  = 1'b1;
      win_aged = 1'b0;
      win_id   = ID_RST;
      if (rst_tb_valid) begin
         win_id = ID_RST;
      end else if (req_aged) begin
         win_id   = ID_REQ;
         win_aged = 1'b1;
      end else if (dma_aged) begin
         win_id   = ID_DMA;
         win_aged = 1'b1;
      end else if (rsp_in_valid) begin
         win_id = ID_RSP;
      end else if (elig_req) begin
         win_id = ID_REQ;
      end else if (elig_dma) begin
         win_id = ID_DMA;
      end else begin
         win_any = 1'b0;
      end
   end

   assign grant            = arb_en && win_any;
   assign rst_tb_ready     = grant && (win_id == ID_RST);
   assign rsp_in_ready     = grant && (win_id == ID_RSP);
   assign req_in_ready     = grant && (win_id == ID_REQ);
   assign dma_req_in_ready = grant && (win_id == ID_DMA);
   assign starve_flag      = grant && win_aged;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         arm_q     <= 1'b0;
         sel_valid <= 1'b0;
         sel_id    <= ID_RST;
         req_age   <= '0;
         dma_age   <= '0;
      end else begin
         arm_q <= 1'b1;
         case (state)
            IDLE: begin
               if (grant) begin
                  state     <= BUSY;
                  sel_valid <= 1'b1;
                  sel_id    <= win_id;
               end
            end
            BUSY: begin
               if (txn_done) begin
                  state     <= IDLE;
                  sel_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (!elig_req)
            req_age <= '0;
         else if (grant) begin
            if (win_id == ID_REQ)
               req_age <= '0;
            else if (req_age != AGE_MAX)
               req_age <= req_age + 1'b1;
         end

         if (!elig_dma)
            dma_age <= '0;
         else if (grant) begin
            if (win_id == ID_DMA)
               dma_age <= '0;
            else if (dma_age != AGE_MAX)
               dma_age <= dma_age + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Directed bench for llc_input_arbiter: reset, priority, aging, blocking, hold and reset-in-flight.
module tb_llc_input_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       rst_tb_valid, rsp_in_valid, req_in_valid, dma_req_in_valid;
   logic       block_req, block_dma, decode_en, txn_done;
   logic       rst_tb_ready, rsp_in_ready, req_in_ready, dma_req_in_ready;
   logic       sel_valid;
   logic [1:0] sel_id;
   logic       starve_flag;
   logic [3:0] rdy;

   int n_tests = 0;
   int n_fail  = 0;

   llc_input_arbiter #(.STARVE_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .rst_tb_valid(rst_tb_valid), .rsp_in_valid(rsp_in_valid),
      .req_in_valid(req_in_valid), .dma_req_in_valid(dma_req_in_valid),
      .block_req(block_req), .block_dma(block_dma),
      .decode_en(decode_en), .txn_done(txn_done),
      .rst_tb_ready(rst_tb_ready), .rsp_in_ready(rsp_in_ready),
      .req_in_ready(req_in_ready), .dma_req_in_ready(dma_req_in_ready),
      .sel_valid(sel_valid), .sel_id(sel_id), .starve_flag(starve_flag)
   );

   always #5 clk = ~clk;

   // ready vector ordered {rst_tb, rsp, req, dma}
   assign rdy = {rst_tb_ready, rsp_in_ready, req_in_ready, dma_req_in_ready};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_valids(input logic [3:0] v);
      {rst_tb_valid, rsp_in_valid, req_in_valid, dma_req_in_valid} = v;
   endtask

   task automatic done_pulse();
      txn_done = 1'b1;
      tick();
      txn_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; set_valids(4'b1111);
      block_req = 1'b0; block_dma = 1'b0; decode_en = 1'b1; txn_done = 1'b0;

      // T1 reset
      tick();
      chk("t1_rdy_in_rst", 32'(rdy), 32'h0);
      tick();
      chk("t1_rdy_in_rst2", 32'(rdy), 32'h0);
      chk("t1_selv_in_rst", 32'(sel_valid), 32'h0);
      chk("t1_selid_in_rst", 32'(sel_id), 32'h0);
      rst = 1'b0;
      #1;
      chk("t1_rdy_after_rst", 32'(rdy), 32'h0);
      tick();
      chk("t1_first_grant", 32'(rdy), 32'b1000);
      chk("t1_starve0", 32'(starve_flag), 32'h0);
      tick();
      chk("t1_selv", 32'(sel_valid), 32'h1);
      chk("t1_selid", 32'(sel_id), 32'h0);
      chk("t1_busy_rdy", 32'(rdy), 32'h0);
      done_pulse();
      set_valids(4'b0000);
      #1;
      chk("t1_idle_selv", 32'(sel_valid), 32'h0);
      tick();

      // T2 priority: rsp over req over dma
      set_valids(4'b0111);
      #1;
      chk("t2_rsp_rdy", 32'(rdy), 32'b0100);
      tick();
      chk("t2_selid_rsp", 32'(sel_id), 32'h1);
      rsp_in_valid = 1'b0;
      done_pulse();
      #1;
      chk("t2_req_rdy", 32'(rdy), 32'b0010);
      tick();
      chk("t2_selid_req", 32'(sel_id), 32'h2);
      set_valids(4'b0000);
      done_pulse();

      // T3 starvation: rsp wins 8 times, then aged req
      set_valids(4'b0110);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t3_rsp_rdy", 32'(rdy), 32'b0100);
         chk("t3_no_starve", 32'(starve_flag), 32'h0);
         tick();
         chk("t3_selid_rsp", 32'(sel_id), 32'h1);
         done_pulse();
      end
      #1;
      chk("t3_aged_req_rdy", 32'(rdy), 32'b0010);
      chk("t3_starve", 32'(starve_flag), 32'h1);
      tick();
      chk("t3_selid_req", 32'(sel_id), 32'h2);
      chk("t3_starve_off", 32'(starve_flag), 32'h0);
      chk("t3_req_age0", 32'(dut.req_age), 32'h0);
      done_pulse();
      #1;
      chk("t3_rsp_again", 32'(rdy), 32'b0100);
      chk("t3_no_starve2", 32'(starve_flag), 32'h0);
      set_valids(4'b0000);
      tick();

      // T4 blocking
      set_valids(4'b0011);
      block_req = 1'b1;
      #1;
      chk("t4_dma_rdy", 32'(rdy), 32'b0001);
      tick();
      chk("t4_selid_dma", 32'(sel_id), 32'h3);
      chk("t4_req_age0", 32'(dut.req_age), 32'h0);
      block_req = 1'b0;
      dma_req_in_valid = 1'b0;
      done_pulse();
      #1;
      chk("t4_req_rdy", 32'(rdy), 32'b0010);
      tick();
      chk("t4_selid_req", 32'(sel_id), 32'h2);

      // T5 hold: in BUSY with req, everything valid, no txn_done
      set_valids(4'b1111);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t5_hold_rdy", 32'(rdy), 32'h0);
         chk("t5_hold_selid", 32'(sel_id), 32'h2);
         chk("t5_hold_selv", 32'(sel_valid), 32'h1);
      end
      done_pulse();
      chk("t5_released", 32'(sel_valid), 32'h0);
      set_valids(4'b0000);
      tick();

      // T6 reset while BUSY
      set_valids(4'b0011);
      #1;
      chk("t6_req_rdy", 32'(rdy), 32'b0010);
      tick();
      chk("t6_selv", 32'(sel_valid), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_valids(4'b0000);
      #1;
      chk("t6_selv_cleared", 32'(sel_valid), 32'h0);
      chk("t6_selid_cleared", 32'(sel_id), 32'h0);
      chk("t6_req_age", 32'(dut.req_age), 32'h0);
      chk("t6_dma_age", 32'(dut.dma_age), 32'h0);
      chk("t6_rdy_after_rst", 32'(rdy), 32'h0);
      done_pulse();
      chk("t6_stale_done_selv", 32'(sel_valid), 32'h0);
      chk("t6_stale_done_rdy", 32'(rdy), 32'h0);
      dma_req_in_valid = 1'b1;
      #1;
      chk("t6_dma_rdy", 32'(rdy), 32'b0001);
      tick();
      chk("t6_selid_dma", 32'(sel_id), 32'h3);
      done_pulse();

      // decode_en low in IDLE blocks admission
      decode_en = 1'b0;
      #1;
      chk("t7_no_decode_rdy", 32'(rdy), 32'h0);
      tick();
      chk("t7_no_decode_selv", 32'(sel_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
